// File: rtl/tv_sequencer_pkg.sv
// Shared types and vector field layout for the test-vector sequencer.
// A ROM word is packed as {valid, in, expected}, with expected in the LSBs.
package tvseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Field positions for the default 3-in/1-out configuration.
  localparam int unsigned DEF_IN_W  = 3;
  localparam int unsigned DEF_OUT_W = 1;
  localparam int unsigned EXP_LSB   = 0;
  localparam int unsigned IN_LSB    = DEF_OUT_W;
  localparam int unsigned VALID_BIT = DEF_IN_W + DEF_OUT_W;

  // Same layout for any width combination.
  function automatic int unsigned in_lsb(input int unsigned out_w);
    return out_w;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/tv_sequencer_if.sv
// ROM read bus and DUT stimulus/response bundle of the test-vector sequencer.
// master: the sequencer side; slave: the ROM + device-under-test side.
interface tv_sequencer_if #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned ADDR_W = 4
);

  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [IN_W+OUT_W:0]     mem_rdata;
  logic [IN_W-1:0]         dut_in;
  logic [OUT_W-1:0]        dut_out;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output dut_in,
    input  dut_out
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  dut_in,
    output dut_out
  );

endinterface

// File: rtl/tv_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: reset/clear to zero, increment unless already saturated.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: fetches {valid, in, expected} words from a sync-read
// ROM, applies them to a small combinational DUT, waits SETTLE cycles, then
// compares and counts. A run stops at an end marker (valid=0) or the last ROM
// entry. Optional build macro TVSEQ_STOP_ON_ERR_EN ends the run at the first
// mismatching vector.
module tv_sequencer
  import tvseq_pkg::*;
#(
  parameter  int unsigned IN_W   = 3,
  parameter  int unsigned OUT_W  = 1,
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned SETTLE = 2,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  tv_sequencer_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              pass_pulse,
  output logic              fail_pulse,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int unsigned IN_POS    = in_lsb(OUT_W);
  localparam int unsigned VALID_POS = valid_bit(IN_W, OUT_W);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [OUT_W-1:0]  exp_q;
  logic [3:0]        settle_cnt;

  logic              rd_valid;
  logic              match;
  logic              last_addr;
  logic              run_start;
  logic              vec_inc;
  logic              err_inc;

  assign rd_valid     = bus.mem_rdata[VALID_POS];
  assign match        = (bus.dut_out == exp_q);
  assign last_addr    = (addr == ADDR_W'(DEPTH - 1));
  // addr only moves when leaving CHECK, so the address bus naturally holds
  // between fetches.
  assign bus.mem_addr = addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and per-state strobes/status.
  always_comb begin
    state_nx      = state;
    bus.mem_rd_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    pass_pulse    = 1'b0;
    fail_pulse    = 1'b0;
    run_start     = 1'b0;
    vec_inc       = 1'b0;
    err_inc       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_nx  = S_FETCH;
        end
      end
      S_FETCH: begin
        busy          = 1'b1;
        bus.mem_rd_en = 1'b1;
        state_nx      = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        state_nx = rd_valid ? S_SETTLE : S_DONE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt <= 4'd1) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        busy    = 1'b1;
        vec_inc = 1'b1;
        if (match) begin
          pass_pulse = 1'b1;
        end else begin
          fail_pulse = 1'b1;
          err_inc    = 1'b1;
        end
`ifdef TVSEQ_STOP_ON_ERR_EN
        if (!match || last_addr) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_FETCH;
        end
`else
        state_nx = last_addr ? S_DONE : S_FETCH;
`endif
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          run_start = 1'b1;
          state_nx  = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: address, applied vector, expected value, settle timer, first-fail address.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      bus.dut_in <= '0;
      exp_q      <= '0;
      settle_cnt <= '0;
      fail_addr  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (run_start) begin
            addr      <= '0;
            fail_addr <= '0;
          end
        end
        S_LOAD: begin
          if (rd_valid) begin
            bus.dut_in <= bus.mem_rdata[IN_POS +: IN_W];
            exp_q      <= bus.mem_rdata[EXP_LSB +: OUT_W];
            settle_cnt <= 4'(SETTLE);
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        S_CHECK: begin
          // err_count is still pre-increment here, so zero marks the first error.
          if (!match && (err_count == '0)) begin
            fail_addr <= addr;
          end
          if (state_nx == S_FETCH) begin
            addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .inc   (vec_inc),
    .count (vec_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_tv_sequencer.sv
// Directed bench for tv_sequencer: DUT model y = a&~b | c with in = {a,b,c},
// sync-read ROM model, SETTLE=2, DEPTH=16.
module tb_tv_sequencer;

  localparam int unsigned IN_W   = 3;
  localparam int unsigned OUT_W  = 1;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 4;

`ifdef TVSEQ_STOP_ON_ERR_EN
  localparam int E2_CYC  = 30;
  localparam int E2_VEC  = 6;
  localparam int E2_PASS = 5;
  localparam int E2_DIN  = 5;
  localparam int E2_ADDR = 5;
`else
  localparam int E2_CYC  = 42;
  localparam int E2_VEC  = 8;
  localparam int E2_PASS = 7;
  localparam int E2_DIN  = 7;
  localparam int E2_ADDR = 8;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, pass_pulse, fail_pulse;
  logic [CNT_W-1:0]  vec_count, err_count;
  logic [ADDR_W-1:0] fail_addr;

  tv_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  tv_sequencer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pass_pulse (pass_pulse),
    .fail_pulse (fail_pulse),
    .vec_count  (vec_count),
    .err_count  (err_count),
    .fail_addr  (fail_addr)
  );

  always #5 clk = ~clk;

  // ROM model: data one cycle after the read strobe.
  logic [4:0] rom [16];
  logic [4:0] rdata_q = '0;
  always @(posedge clk) if (bus.mem_rd_en) rdata_q <= rom[bus.mem_addr];
  assign bus.mem_rdata = rdata_q;

  // Device under test: y = a&~b | c.
  assign bus.dut_out = (bus.dut_in[2] & ~bus.dut_in[1]) | bus.dut_in[0];

  // Running totals of pulses and of fetches at address 0.
  int pass_tot = 0, fail_tot = 0, f0_tot = 0;
  always @(negedge clk) begin
    if (pass_pulse) pass_tot <= pass_tot + 1;
    if (fail_pulse) fail_tot <= fail_tot + 1;
    if (bus.mem_rd_en && bus.mem_addr == 4'd0) f0_tot <= f0_tot + 1;
  end

  int tests = 0, errs = 0;
  int cur_cyc = 0;
  int p0, fl0, z0;
  logic [7:0] ytab = 8'b1011_1010;   // hand-computed y for in = 0..7

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"},   32'(busy), 0);
    check({pfx, "_done"},   32'(done), 0);
    check({pfx, "_pulses"}, 32'({pass_pulse, fail_pulse}), 0);
    check({pfx, "_vec"},    32'(vec_count), 0);
    check({pfx, "_err"},    32'(err_count), 0);
    check({pfx, "_faddr"},  32'(fail_addr), 0);
    check({pfx, "_din"},    32'(bus.dut_in), 0);
    check({pfx, "_rden"},   32'(bus.mem_rd_en), 0);
    check({pfx, "_maddr"},  32'(bus.mem_addr), 0);
  endtask

  task automatic load_good(input int bad_idx);
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 8; i++) begin
      rom[i] = {1'b1, 3'(i), ytab[i]};
      if (i == bad_idx) rom[i][0] = ~ytab[i];
    end
  endtask

  task automatic load_full();
    for (int i = 0; i < 16; i++) rom[i] = {1'b1, 3'(i % 8), ytab[i % 8]};
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cur_cyc++;
    end
  endtask

  // Called just after a negedge; start is sampled at the next posedge (cycle 0).
  task automatic kick();
    #1;
    p0 = pass_tot; fl0 = fail_tot; z0 = f0_tot;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur_cyc = 0;
  endtask

  task automatic wait_done();
    while (!done && cur_cyc < 300) step(1);
    #1;
  endtask

  initial begin
    load_good(-1);

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: all vectors correct.
    kick();
    wait_done();
    check("t1_cycles", 32'(cur_cyc), 42);
    check("t1_vec",    32'(vec_count), 8);
    check("t1_err",    32'(err_count), 0);
    check("t1_faddr",  32'(fail_addr), 0);
    check("t1_pass",   32'(pass_tot - p0), 8);
    check("t1_fail",   32'(fail_tot - fl0), 0);
    check("t1_din",    32'(bus.dut_in), 7);
    check("t1_maddr",  32'(bus.mem_addr), 8);
    check("t1_busy",   32'(busy), 0);
    step(3); #1;
    check("t1_done_hold", 32'(done), 1);

    // 4: end marker at entry 0.
    for (int i = 0; i < 16; i++) rom[i] = '0;
    kick();
    wait_done();
    check("t4_cycles", 32'(cur_cyc), 2);
    check("t4_vec",    32'(vec_count), 0);
    check("t4_pulses", 32'((pass_tot - p0) + (fail_tot - fl0)), 0);

    // 3: full ROM, no end marker.
    load_full();
    kick();
    wait_done();
    check("t3_cycles", 32'(cur_cyc), 80);
    check("t3_vec",    32'(vec_count), 16);
    check("t3_err",    32'(err_count), 0);
    check("t3_maddr",  32'(bus.mem_addr), 15);
    check("t3_fetch0", 32'(f0_tot - z0), 1);
    check("t3_pass",   32'(pass_tot - p0), 16);

    // 2: entry 5 has the wrong expected value.
    load_good(5);
    kick();
    wait_done();
    check("t2_cycles", 32'(cur_cyc), E2_CYC);
    check("t2_vec",    32'(vec_count), E2_VEC);
    check("t2_err",    32'(err_count), 1);
    check("t2_faddr",  32'(fail_addr), 5);
    check("t2_fail",   32'(fail_tot - fl0), 1);
    check("t2_pass",   32'(pass_tot - p0), E2_PASS);
    check("t2_din",    32'(bus.dut_in), E2_DIN);
    check("t2_maddr",  32'(bus.mem_addr), E2_ADDR);

    // 6b: start from DONE clears counters and repeats the same results.
    kick();
    #1;
    check("t6b_clr_vec",   32'(vec_count), 0);
    check("t6b_clr_err",   32'(err_count), 0);
    check("t6b_clr_faddr", 32'(fail_addr), 0);
    check("t6b_clr_done",  32'(done), 0);
    wait_done();
    check("t6b_cycles", 32'(cur_cyc), E2_CYC);
    check("t6b_vec",    32'(vec_count), E2_VEC);
    check("t6b_err",    32'(err_count), 1);
    check("t6b_faddr",  32'(fail_addr), 5);
    check("t6b_fail",   32'(fail_tot - fl0), 1);

    // 6a: start pulsed while busy is ignored.
    load_good(-1);
    kick();
    step(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();
    check("t6a_cycles", 32'(cur_cyc), 42);
    check("t6a_vec",    32'(vec_count), 8);
    check("t6a_pass",   32'(pass_tot - p0), 8);

    // 5: reset (with a coincident start) during SETTLE of vector 3.
    kick();
    step(17); #1;
    check("t5_busy_pre", 32'(busy), 1);
    check("t5_vec_pre",  32'(vec_count), 3);
    check("t5_din_pre",  32'(bus.dut_in), 3);
    reset = 1'b1;
    start = 1'b1;
    step(1); #1;
    check_idle("t5_rst");
    reset = 1'b0;
    start = 1'b0;
    step(2); #1;
    check("t5_idle_stays", 32'(busy), 0);
    kick();
    wait_done();
    check("t5_cycles", 32'(cur_cyc), 42);
    check("t5_vec",    32'(vec_count), 8);
    check("t5_err",    32'(err_count), 0);
    check("t5_pass",   32'(pass_tot - p0), 8);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
